isb_train_arb: RTL

- Shares the single ISB training port (valid, pc, addr) between two access-stream requesters, e.g. two L1 miss streams.
- Each requester has a small FIFO. A round-robin arbiter pops at most one entry per cycle into a registered output stage that drives the ISB training inputs.
- Requesters see back-pressure through per-port full flags. Dropped accesses are counted for performance analysis.

---
 rtl/isb_pkg.sv | 16 +
 rtl/isb_train_fifo.sv | 65 ++++++
 rtl/isb_train_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/isb_pkg.sv
// Shared types and constants for the ISB training-port arbiter.
package isb_pkg;

  localparam int PC_W   = 16;
  localparam int ADDR_W = 16;

  // Saturation ceiling for the per-requester drop counters.
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // One training access as carried through the requester FIFOs.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
  } train_req_t;

endpackage

// File: rtl/isb_train_fifo.sv
// Small per-requester FIFO. A full FIFO refuses a push even when it is
// popped in the same cycle; popping an empty FIFO is ignored.
module isb_train_fifo
  import isb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = train_req_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  T              mem_q [DEPTH];

  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);

  // Next-state for pointers (wrap naturally at power-of-two DEPTH) and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/isb_train_arb.sv
// Two-requester round-robin arbiter feeding the single ISB training port
// through a registered output stage, with saturating drop counters.
module isb_train_arb
  import isb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = isb_pkg::PC_W,
  parameter int ADDR_W = isb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v0,
  input  logic [PC_W-1:0]   pc0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              full0,
  input  logic              v1,
  input  logic [PC_W-1:0]   pc1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              full1,
  input  logic              isb_busy,
  output logic              v_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       drop0,
  output logic [15:0]       drop1
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
  } req_t;

  req_t          in0, in1, head0, head1;
  logic [CW-1:0] count0, count1;
  logic          ne0, ne1, gnt0, gnt1;

  logic              last_grant_q, last_grant_d;
  logic              v_out_q, v_out_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [15:0]       drop0_q, drop0_d, drop1_q, drop1_d;

  assign in0 = '{pc: pc0, addr: addr0};
  assign in1 = '{pc: pc1, addr: addr1};

  isb_train_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo0 (
    .clk(clk), .reset(reset), .push(v0), .push_data(in0),
    .pop(gnt0), .head(head0), .count(count0), .full(full0)
  );

  isb_train_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo1 (
    .clk(clk), .reset(reset), .push(v1), .push_data(in1),
    .pop(gnt1), .head(head1), .count(count1), .full(full1)
  );

  assign ne0 = (count0 != '0);
  assign ne1 = (count1 != '0);

  // Round-robin grant, output-stage next values and drop counting.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    last_grant_d = last_grant_q;
    if (!isb_busy) begin
      if (ne0 && ne1) begin
        // Contention: the port that did not win last time goes now.
        if (last_grant_q) gnt0 = 1'b1;
        else              gnt1 = 1'b1;
        last_grant_d = ~last_grant_q;
      end else if (ne0) begin
        gnt0 = 1'b1;
      end else if (ne1) begin
        gnt1 = 1'b1;
      end
    end

    v_out_d    = gnt0 | gnt1;
    pc_out_d   = pc_out_q;
    addr_out_d = addr_out_q;
    if (gnt0) begin
      pc_out_d   = head0.pc;
      addr_out_d = head0.addr;
    end else if (gnt1) begin
      pc_out_d   = head1.pc;
      addr_out_d = head1.addr;
    end

    drop0_d = drop0_q;
    drop1_d = drop1_q;
    if (v0 && full0 && drop0_q != DROP_MAX) drop0_d = drop0_q + 16'd1;
    if (v1 && full1 && drop1_q != DROP_MAX) drop1_d = drop1_q + 16'd1;
  end

  // Registered output stage, arbitration history and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      v_out_q      <= 1'b0;
      pc_out_q     <= '0;
      addr_out_q   <= '0;
      drop0_q      <= '0;
      drop1_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      v_out_q      <= v_out_d;
      pc_out_q     <= pc_out_d;
      addr_out_q   <= addr_out_d;
      drop0_q      <= drop0_d;
      drop1_q      <= drop1_d;
    end
  end

  assign v_out    = v_out_q;
  assign pc_out   = pc_out_q;
  assign addr_out = addr_out_q;
  assign drop0    = drop0_q;
  assign drop1    = drop1_q;

endmodule
